// File: rtl/spi_slave_ctrl.sv
// SPI slave front end for a small memory: deframes command + payload
// from MOSI and serializes memory read data back on MISO.
//
// Ports:
//   clk, rstn      single clock (SPI bits sampled on its rising edge),
//                  asynchronous active-low reset
//   SS_n           slave select, active low, marks frame boundaries
//   MOSI / MISO    serial data in / read data out, MSB first
//   rx_data        frame to memory: [DATA_W+1:DATA_W] command, rest payload
//   rx_valid       one-cycle strobe qualifying rx_data
//   tx_data        read data from memory
//   tx_valid       level qualifier for tx_data
module spi_slave_ctrl #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              SS_n,
    input  logic              MOSI,
    output logic              MISO,
    output logic [DATA_W+1:0] rx_data,
    output logic              rx_valid,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid
);

    localparam int CNT_W = $clog2(DATA_W + 2);

    typedef enum logic [2:0] {
        IDLE,
        CHK_CMD,
        WRITE,
        READ_ADD,
        READ_DATA
    } state_e;

    state_e              state_q, state_d;
    logic [DATA_W:0]     shift_q, shift_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                done_q, done_d;
    logic                rd_addr_done_q, rd_addr_done_d;
    logic [DATA_W+1:0]   rx_data_q, rx_data_d;
    logic                rx_valid_q, rx_valid_d;
    logic                tx_acc_q, tx_acc_d;
    logic [DATA_W-1:0]   tx_shift_q, tx_shift_d;
    logic [CNT_W-1:0]    ser_left_q, ser_left_d;
    logic                ser_act_q, ser_act_d;
    logic                miso_q, miso_d;

    always_comb begin
        state_d        = state_q;
        shift_d        = shift_q;
        cnt_d          = cnt_q;
        done_d         = done_q;
        rd_addr_done_d = rd_addr_done_q;
        rx_data_d      = rx_data_q;
        rx_valid_d     = 1'b0;
        tx_acc_d       = tx_acc_q;
        tx_shift_d     = tx_shift_q;
        ser_left_d     = ser_left_q;
        ser_act_d      = ser_act_q;
        miso_d         = miso_q;

        if (state_q != IDLE && SS_n) begin
            // Deselect aborts whatever is in flight; rd_addr_done is kept.
            state_d    = IDLE;
            cnt_d      = '0;
            done_d     = 1'b0;
            tx_acc_d   = 1'b0;
            ser_act_d  = 1'b0;
            ser_left_d = '0;
            miso_d     = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    cnt_d      = '0;
                    done_d     = 1'b0;
                    tx_acc_d   = 1'b0;
                    ser_act_d  = 1'b0;
                    ser_left_d = '0;
                    miso_d     = 1'b0;
                    if (!SS_n) state_d = CHK_CMD;
                end
                CHK_CMD: begin
                    shift_d = {shift_q[DATA_W-1:0], MOSI};
                    cnt_d   = '0;
                    if (!MOSI)               state_d = WRITE;
                    else if (rd_addr_done_q) state_d = READ_DATA;
                    else                     state_d = READ_ADD;
                end
                WRITE, READ_ADD, READ_DATA: begin
                    if (!done_q) begin
                        shift_d = {shift_q[DATA_W-1:0], MOSI};
                        if (cnt_q == CNT_W'(DATA_W)) begin
                            rx_data_d  = {shift_q, MOSI};
                            rx_valid_d = 1'b1;
                            done_d     = 1'b1;
                            if (state_q == READ_ADD)  rd_addr_done_d = 1'b1;
                            if (state_q == READ_DATA) rd_addr_done_d = 1'b0;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end else if (state_q == READ_DATA && !tx_acc_q
                                 && tx_valid) begin
                        // done_q is only set after the last-bit edge, so a
                        // tx_valid level present during the frame is ignored.
                        tx_acc_d   = 1'b1;
                        ser_act_d  = 1'b1;
                        miso_d     = tx_data[DATA_W-1];
                        tx_shift_d = tx_data << 1;
                        ser_left_d = CNT_W'(DATA_W - 1);
                    end
                end
                default: state_d = IDLE;
            endcase

            if (ser_act_q) begin
                if (ser_left_q != '0) begin
                    miso_d     = tx_shift_q[DATA_W-1];
                    tx_shift_d = tx_shift_q << 1;
                    ser_left_d = ser_left_q - CNT_W'(1);
                end else begin
                    miso_d    = 1'b0;
                    ser_act_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q        <= IDLE;
            shift_q        <= '0;
            cnt_q          <= '0;
            done_q         <= 1'b0;
            rd_addr_done_q <= 1'b0;
            rx_data_q      <= '0;
            rx_valid_q     <= 1'b0;
            tx_acc_q       <= 1'b0;
            tx_shift_q     <= '0;
            ser_left_q     <= '0;
            ser_act_q      <= 1'b0;
            miso_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            shift_q        <= shift_d;
            cnt_q          <= cnt_d;
            done_q         <= done_d;
            rd_addr_done_q <= rd_addr_done_d;
            rx_data_q      <= rx_data_d;
            rx_valid_q     <= rx_valid_d;
            tx_acc_q       <= tx_acc_d;
            tx_shift_q     <= tx_shift_d;
            ser_left_q     <= ser_left_d;
            ser_act_q      <= ser_act_d;
            miso_q         <= miso_d;
        end
    end

    assign MISO     = miso_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;

endmodule

// File: tb/tb_spi_slave_ctrl.sv
// Scoreboard bench for spi_slave_ctrl: stimulus pushes expected frames
// and MISO bits; a negedge monitor pops and compares.
module tb_spi_slave_ctrl;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rstn;
    logic          SS_n;
    logic          MOSI;
    logic          MISO;
    logic [DW+1:0] rx_data;
    logic          rx_valid;
    logic [DW-1:0] tx_data;
    logic          tx_valid;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct packed {
        int   c;
        logic b;
    } miso_t;

    logic [DW+1:0] rx_q[$];
    miso_t         miso_q[$];

    spi_slave_ctrl #(.DATA_W(DW)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .SS_n     (SS_n),
        .MOSI     (MOSI),
        .MISO     (MISO),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_valid (tx_valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // Monitor
    always @(negedge clk) begin
        if (rstn) begin
            if (rx_valid) begin
                if (rx_q.size() == 0) begin
                    check("rx_unexpected", 32'(rx_data), 32'hFFFF_FFFF);
                end else begin
                    check("rx_data", 32'(rx_data), 32'(rx_q.pop_front()));
                end
            end
            if (miso_q.size() > 0 && miso_q[0].c == cyc) begin
                miso_t e;
                e = miso_q.pop_front();
                check("miso_bit", 32'(MISO), 32'(e.b));
            end else begin
                check("miso_idle", 32'(MISO), 32'd0);
            end
        end
    end

    task automatic send_frame(input logic [DW+1:0] f, output int last_c);
        rx_q.push_back(f);
        @(negedge clk);
        SS_n = 1'b0;
        MOSI = f[DW+1];
        @(negedge clk);
        MOSI = f[DW+1];
        for (int i = DW; i >= 0; i--) begin
            @(negedge clk);
            MOSI = f[i];
        end
        last_c = cyc;
    endtask

    task automatic end_frame();
        @(negedge clk);
        SS_n = 1'b1;
        MOSI = 1'b0;
        @(negedge clk);
    endtask

    task automatic expect_miso(input logic [DW-1:0] d, input int first_c);
        for (int i = 0; i < DW; i++)
            miso_q.push_back('{c: first_c + i, b: d[DW-1-i]});
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: timeout at cyc %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int lc;
        logic [DW+1:0] pf;
        rstn = 1'b0;
        SS_n = 1'b1;
        MOSI = 1'b0;
        tx_data = '0;
        tx_valid = 1'b0;
        #22;
        check("rst_rx_data", 32'(rx_data), 32'd0);
        check("rst_rx_valid", 32'(rx_valid), 32'd0);
        check("rst_miso", 32'(MISO), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        wait_cycles(2);

        // Write address, then stray MOSI bits after completion
        send_frame(10'h005, lc);
        repeat (4) begin
            @(negedge clk);
            MOSI = ~MOSI;
        end
        end_frame();
        check("rx_hold", 32'(rx_data), 32'h005);

        // Write data
        send_frame(10'h1AA, lc);
        wait_cycles(2);
        end_frame();

        // Read address; tx_valid high must not serialize (READ_ADD)
        tx_valid = 1'b1;
        tx_data = 8'hFF;
        send_frame(10'h205, lc);
        wait_cycles(12);
        end_frame();
        tx_valid = 1'b0;

        // Write between read frames keeps rd_addr_done
        send_frame(10'h0F0, lc);
        wait_cycles(2);
        end_frame();

        // Read data: tx_valid two cycles after the last bit
        send_frame(10'h33C, lc);
        wait_cycles(2);
        tx_data = 8'hAA;
        tx_valid = 1'b1;
        expect_miso(8'hAA, cyc + 1);
        wait_cycles(DW + 4);
        end_frame();

        // rd_addr_done cleared: next read goes to READ_ADD
        tx_data = 8'h55;
        send_frame(10'h2C3, lc);
        wait_cycles(12);
        end_frame();

        // Stale tx_valid held high through a READ_DATA frame
        send_frame(10'h381, lc);
        expect_miso(8'h55, lc + 2);
        wait_cycles(DW + 8);
        end_frame();
        tx_valid = 1'b0;

        // Abort after 5 bits of a write frame
        pf = 10'h0FF;
        @(negedge clk);
        SS_n = 1'b0;
        MOSI = pf[DW+1];
        @(negedge clk);
        MOSI = pf[DW+1];
        for (int i = DW; i > DW - 4; i--) begin
            @(negedge clk);
            MOSI = pf[i];
        end
        end_frame();
        send_frame(10'h0A5, lc);
        wait_cycles(2);
        end_frame();

        // Reset after three MISO bits
        send_frame(10'h211, lc);
        wait_cycles(2);
        end_frame();
        send_frame(10'h300, lc);
        wait_cycles(2);
        tx_data = 8'hC3;
        tx_valid = 1'b1;
        expect_miso(8'hC3, cyc + 1);
        wait_cycles(3);
        #2;
        rstn = 1'b0;
        #1;
        miso_q.delete();
        check("rstmid_miso", 32'(MISO), 32'd0);
        check("rstmid_rx_valid", 32'(rx_valid), 32'd0);
        check("rstmid_rx_data", 32'(rx_data), 32'd0);
        SS_n = 1'b1;
        tx_valid = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        wait_cycles(2);

        // After reset rd_addr_done=0: read goes to READ_ADD
        tx_data = 8'h81;
        tx_valid = 1'b1;
        send_frame(10'h3FF, lc);
        wait_cycles(12);
        end_frame();

        // Now READ_DATA serializes once
        send_frame(10'h200, lc);
        expect_miso(8'h81, lc + 2);
        wait_cycles(DW + 6);
        end_frame();
        tx_valid = 1'b0;
        wait_cycles(4);

        check("rx_queue_empty", 32'(rx_q.size()), 32'd0);
        check("miso_queue_empty", 32'(miso_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_slave_ctrl.md
SPI_SLAVE_CTRL -- requirements
Module: spi_slave_ctrl

Interface
REQ-001 Parameter: DATA_W, default 8, memory data/address payload width; frame width is DATA_W+2.
REQ-002 Port: clk  input  1  single clock; SPI bits are sampled and driven on its rising edge.
REQ-003 Port: rstn  input  1  asynchronous, active-low reset.
REQ-004 Port: SS_n  input  1  slave select, active low; frame boundary.
REQ-005 Port: MOSI  input  1  serial data in, MSB first.
REQ-006 Port: MISO  output  1  serial read data out, MSB first.
REQ-007 Port: rx_data  output  DATA_W+2  assembled frame to the memory: [DATA_W+1:DATA_W] is the command, [DATA_W-1:0] is the payload.
REQ-008 Port: rx_valid  output  1  one-cycle strobe; rx_data is valid.
REQ-009 Port: tx_data  input  DATA_W  read data from the memory.
REQ-010 Port: tx_valid  input  1  tx_data is valid; level signal, may stay high.

Function
REQ-011 The FSM SHALL use the states IDLE, CHK_CMD, WRITE, READ_ADD and READ_DATA, all registered.
REQ-012 IDLE: SS_n sampled low -> CHK_CMD; otherwise remain in IDLE.
REQ-013 CHK_CMD SHALL sample MOSI as frame bit DATA_W+1.
  - MOSI=0 -> WRITE.
  - MOSI=1 with rd_addr_done=0 -> READ_ADD.
  - MOSI=1 with rd_addr_done=1 -> READ_DATA.
REQ-014 WRITE, READ_ADD and READ_DATA SHALL shift in the remaining DATA_W+1 bits, one per cycle, MSB first, counted by a bit counter.
REQ-015 On the edge that samples the last bit, the block SHALL load rx_data and set rx_valid for exactly one cycle.
  - rx_data holds that value until the next completed frame.
REQ-016 Routing SHALL depend on rd_addr_done only; the second command bit is passed through in rx_data unchecked.
REQ-017 A completed READ_ADD frame SHALL set rd_addr_done; a completed READ_DATA frame SHALL clear it; WRITE frames SHALL leave it unchanged.
REQ-018 After its rx_valid pulse, READ_DATA SHALL wait for tx_valid=1 sampled on a later edge.
  - Only the first such sample per frame counts.
  - A tx_valid level that was already high before the rx_valid pulse SHALL be ignored.
REQ-019 On accepting tx_valid, the block SHALL latch tx_data and drive it on MISO over the next DATA_W cycles, MSB first, one bit per cycle.
REQ-020 MISO SHALL be 0 whenever the block is not serializing.
REQ-021 After the frame (and the read serialization, if any) completes, the block SHALL hold its state with no further rx_valid until SS_n is sampled high, then go to IDLE.
REQ-022 Extra MOSI bits after frame completion SHALL be ignored.
REQ-023 SS_n sampled high in any non-IDLE state SHALL return the FSM to IDLE on that edge and abort the frame:
  - no rx_valid;
  - rd_addr_done unchanged;
  - any serialization in progress stops;
  - bit counter cleared;
  - MISO=0 on the following cycle.
REQ-024 A new frame SHALL require at least one cycle in IDLE; SS_n low on the IDLE-return edge SHALL be seen on the next edge.

Reset
REQ-025 rstn low SHALL asynchronously force:
  - state=IDLE, rx_data=0, rx_valid=0, MISO=0;
  - rd_addr_done=0;
  - bit counter=0;
  - the tx latch and the tx-accepted flag cleared.
REQ-026 rstn low mid-frame SHALL discard the partial frame; operation resumes only from IDLE after rstn deasserts.

Verification
REQ-027 Write address: SS_n low, MOSI 00_0000_0101 -> one rx_valid pulse with rx_data=10'h005; rd_addr_done stays 0.
REQ-028 Write data: frame 01_1010_1010 -> rx_data=10'h1AA; then SS_n high -> IDLE.
REQ-029 Read sequence:
  - frame 10_0000_0101 -> rx_data=10'h205 and rd_addr_done=1;
  - next frame 11_xxxx_xxxx -> rx_data[9:8]=2'b11;
  - tx_valid=1 with tx_data=8'hAA two cycles later -> MISO 1,0,1,0,1,0,1,0 on 8 consecutive cycles, then MISO=0;
  - rd_addr_done=0 afterwards.
REQ-030 Abort: SS_n high after 5 bits of a write frame -> no rx_valid; next full frame decodes correctly.
REQ-031 Stale tx_valid: tx_valid held high throughout a READ_DATA frame -> serialization starts only after the rx_valid pulse, exactly once.
REQ-032 Reset mid-serialization (rstn low after 3 MISO bits) -> MISO=0, state=IDLE, rd_addr_done=0 immediately.
